// File: rtl/enemy_bullet_pool.sv
// Enemy bullet pool: periodic/forced firing into the lowest free slot per enemy, per-tick downward motion, retire at Y_LIMIT or on hit clear.
// Latency: every output is registered; inputs sampled at edge k are visible after edge k.
// Backpressure: none; a fire event that finds no free slot is dropped and flagged on o_Dropped.
//
// Ports:
//   i_Clk, i_Rst        clock, asynchronous active-low reset
//   i_Tick, i_Enable    frame-advance strobe, qualified by enable (enable=0 freezes counter and motion)
//   i_FireNow           extra fire event on the current active tick
//   i_EnemyAlive        per-enemy alive mask
//   i_EnemyPos          packed {x,y} muzzle positions, enemy e at [e*POS_W +: POS_W]
//   i_HitClear          per-slot kill request, bit e*SLOTS+s
//   o_BulletValid       slot occupied
//   o_BulletPos         packed {x,y} slot positions, DEAD_POS when the slot is empty
//   o_Fired, o_Dropped  per-enemy one-cycle pulses for allocated / dropped fire events
//   o_FireCnt           current fire counter
module enemy_bullet_pool #(
  parameter int N_ENEMY      = 4,
  parameter int SLOTS        = 4,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int BULLET_SPEED = 5,
  parameter int FIRE_PERIOD  = 128,
  parameter int Y_LIMIT      = 460,
  localparam int POS_W       = X_W + Y_W,
  localparam int CNT_W       = $clog2(FIRE_PERIOD)
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_Tick,
  input  logic                             i_Enable,
  input  logic                             i_FireNow,
  input  logic [N_ENEMY-1:0]               i_EnemyAlive,
  input  logic [N_ENEMY*POS_W-1:0]         i_EnemyPos,
  input  logic [N_ENEMY*SLOTS-1:0]         i_HitClear,
  output logic [N_ENEMY*SLOTS-1:0]         o_BulletValid,
  output logic [N_ENEMY*SLOTS*POS_W-1:0]   o_BulletPos,
  output logic [N_ENEMY-1:0]               o_Fired,
  output logic [N_ENEMY-1:0]               o_Dropped,
  output logic [CNT_W-1:0]                 o_FireCnt
);

  localparam logic [POS_W-1:0] DEAD_POS = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIRE_PERIOD - 1);
  localparam logic [Y_W:0]     Y_LIM    = (Y_W + 1)'(Y_LIMIT);
  localparam logic [Y_W:0]     Y_STEP   = (Y_W + 1)'(BULLET_SPEED);

  logic activeTick;
  logic fireEvent;

  assign activeTick = i_Tick & i_Enable;
  assign fireEvent  = activeTick & ((o_FireCnt == CNT_LAST) | i_FireNow);

  logic [N_ENEMY*SLOTS-1:0]       validNext;
  logic [N_ENEMY*SLOTS*POS_W-1:0] posNext;
  logic [N_ENEMY-1:0]             firedNext;
  logic [N_ENEMY-1:0]             droppedNext;
  logic [N_ENEMY-1:0]             slotTaken;
  logic [Y_W:0]                   yNext;

  always_comb begin
    validNext   = o_BulletValid;
    posNext     = o_BulletPos;
    firedNext   = '0;
    droppedNext = '0;
    slotTaken   = '0;
    yNext       = '0;
    for (int e = 0; e < N_ENEMY; e++) begin
      for (int s = 0; s < SLOTS; s++) begin
        // Motion / clear of the slot as it stood at the start of the cycle.
        if (i_HitClear[e*SLOTS+s]) begin
          validNext[e*SLOTS+s]                  = 1'b0;
          posNext[(e*SLOTS+s)*POS_W +: POS_W]   = DEAD_POS;
        end else if (o_BulletValid[e*SLOTS+s] && activeTick) begin
          // One extra bit so a wrap past 2^Y_W still counts as crossing the limit.
          yNext = {1'b0, o_BulletPos[(e*SLOTS+s)*POS_W +: Y_W]} + Y_STEP;
          if (yNext >= Y_LIM) begin
            validNext[e*SLOTS+s]                = 1'b0;
            posNext[(e*SLOTS+s)*POS_W +: POS_W] = DEAD_POS;
          end else begin
            posNext[(e*SLOTS+s)*POS_W +: Y_W]   = yNext[Y_W-1:0];
          end
        end
        // Allocation only looks at slots that were empty before this cycle, so a
        // slot retiring now is not reused and a hit clear cannot block a birth.
        if (fireEvent && i_EnemyAlive[e] && !o_BulletValid[e*SLOTS+s] && !slotTaken[e]) begin
          validNext[e*SLOTS+s]                  = 1'b1;
          posNext[(e*SLOTS+s)*POS_W +: POS_W]   = i_EnemyPos[e*POS_W +: POS_W];
          slotTaken[e]                          = 1'b1;
        end
      end
      firedNext[e]   = fireEvent & i_EnemyAlive[e] & slotTaken[e];
      droppedNext[e] = fireEvent & i_EnemyAlive[e] & ~slotTaken[e];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_BulletValid <= '0;
      o_BulletPos   <= '1;
      o_Fired       <= '0;
      o_Dropped     <= '0;
      o_FireCnt     <= '0;
    end else begin
      o_BulletValid <= validNext;
      o_BulletPos   <= posNext;
      o_Fired       <= firedNext;
      o_Dropped     <= droppedNext;
      if (activeTick) begin
        o_FireCnt <= (o_FireCnt == CNT_LAST) ? '0 : o_FireCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enemy_bullet_pool.sv
module tb_enemy_bullet_pool;

  localparam int NE = 4;
  localparam int NS = 4;
  localparam int PW = 19;

  logic              clk;
  logic              rst;
  logic              tick;
  logic              en;
  logic              fireNow;
  logic [NE-1:0]     alive;
  logic [NE*PW-1:0]  enemyPos;
  logic [NE*NS-1:0]  hitClear;
  logic [NE*NS-1:0]  bValid;
  logic [NE*NS*PW-1:0] bPos;
  logic [NE-1:0]     fired;
  logic [NE-1:0]     dropped;
  logic [6:0]        fireCnt;

  int total = 0;
  int bad   = 0;

  enemy_bullet_pool dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Tick       (tick),
    .i_Enable     (en),
    .i_FireNow    (fireNow),
    .i_EnemyAlive (alive),
    .i_EnemyPos   (enemyPos),
    .i_HitClear   (hitClear),
    .o_BulletValid(bValid),
    .o_BulletPos  (bPos),
    .o_Fired      (fired),
    .o_Dropped    (dropped),
    .o_FireCnt    (fireCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NE*NS*PW-1:0] got, input logic [NE*NS*PW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         mV [NE][NS];
  logic [9:0] mX [NE][NS];
  int         mY [NE][NS];
  int         mCnt;
  bit [NE-1:0] mFired;
  bit [NE-1:0] mDropped;
  bit         mAct;
  bit         mFire;
  int         mFree;

  task automatic modelReset();
    for (int e = 0; e < NE; e++)
      for (int s = 0; s < NS; s++) begin
        mV[e][s] = 1'b0; mX[e][s] = '0; mY[e][s] = 0;
      end
    mCnt = 0; mFired = '0; mDropped = '0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else begin
      mAct  = tick && en;
      mFire = mAct && ((mCnt == 127) || fireNow);
      if (mAct) mCnt = (mCnt + 1) % 128;
      for (int e = 0; e < NE; e++) begin
        mFree = -1;
        for (int s = NS - 1; s >= 0; s--) if (!mV[e][s]) mFree = s;
        for (int s = 0; s < NS; s++) begin
          if (hitClear[e*NS+s]) mV[e][s] = 1'b0;
          else if (mV[e][s] && mAct) begin
            mY[e][s] = mY[e][s] + 5;
            if (mY[e][s] >= 460) mV[e][s] = 1'b0;
          end
        end
        mFired[e] = 1'b0; mDropped[e] = 1'b0;
        if (mFire && alive[e]) begin
          if (mFree >= 0) begin
            mV[e][mFree] = 1'b1;
            mX[e][mFree] = enemyPos[e*PW+9 +: 10];
            mY[e][mFree] = int'(enemyPos[e*PW +: 9]);
            mFired[e] = 1'b1;
          end else mDropped[e] = 1'b1;
        end
      end
    end
  end

  logic [NE*NS-1:0]    expV;
  logic [NE*NS*PW-1:0] expP;
  logic [8:0]          ySlice;

  always @(negedge clk) begin
    for (int e = 0; e < NE; e++)
      for (int s = 0; s < NS; s++) begin
        expV[e*NS+s] = mV[e][s];
        ySlice = mY[e][s][8:0];
        expP[(e*NS+s)*PW +: PW] = mV[e][s] ? {mX[e][s], ySlice} : 19'h7FFFF;
      end
    chk("cyc_valid",   bValid,  expV);
    chk("cyc_pos",     bPos,    expP);
    chk("cyc_fired",   fired,   mFired);
    chk("cyc_dropped", dropped, mDropped);
    chk("cyc_cnt",     fireCnt, mCnt[6:0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setEnemy(input int e, input logic [9:0] x, input logic [8:0] y);
    enemyPos[e*PW +: PW] = {x, y};
  endtask

  task automatic fireOnce();
    tick = 1'b1; fireNow = 1'b1;
    step(1);
    tick = 1'b0; fireNow = 1'b0;
  endtask

  task automatic tickOnce();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  function automatic logic [PW-1:0] slotPos(input int e, input int s);
    return bPos[(e*NS+s)*PW +: PW];
  endfunction

  initial begin
    modelReset();
    rst = 1'b0; tick = 1'b0; en = 1'b0; fireNow = 1'b0;
    alive = 4'b1111; hitClear = '0; enemyPos = '0;
    setEnemy(0, 10'd230, 9'd48);
    setEnemy(1, 10'd100, 9'd10);
    setEnemy(2, 10'd300, 9'd20);
    setEnemy(3, 10'd500, 9'd30);
    step(2);
    chk("rst_valid", bValid, 16'h0000);
    chk("rst_cnt", fireCnt, 7'd0);
    chk("rst_pos_e0s0", slotPos(0, 0), 19'h7FFFF);
    rst = 1'b1;

    // periodic fire after 128 ticks
    en = 1'b1; tick = 1'b1;
    step(127);
    chk("cnt_127", fireCnt, 7'd127);
    chk("no_fire_yet", fired, 4'b0000);
    step(1);
    chk("wrap_fired", fired, 4'b1111);
    chk("wrap_cnt", fireCnt, 7'd0);
    chk("birth_e0s0", slotPos(0, 0), {10'd230, 9'd48});
    step(1);
    chk("move_e0s0", slotPos(0, 0), {10'd230, 9'd53});
    chk("fired_clears", fired, 4'b0000);
    tick = 1'b0;

    // fill remaining slots, then drop
    fireOnce();
    chk("fill_fired", fired, 4'b1111);
    fireOnce();
    fireOnce();
    chk("full_valid", bValid, 16'hFFFF);
    fireOnce();
    chk("drop_dropped", dropped, 4'b1111);
    chk("drop_fired", fired, 4'b0000);
    chk("drop_e0s1", slotPos(0, 1), {10'd230, 9'd63});

    // hit clear with tick low
    hitClear = 16'h0200;
    step(1);
    hitClear = '0;
    chk("hit_valid", bValid, 16'hFDFF);
    chk("hit_pos", slotPos(2, 1), 19'h7FFFF);

    // partial alive mask
    hitClear = 16'h0F0F;
    step(1);
    hitClear = '0;
    alive = 4'b0101;
    fireOnce();
    chk("alive_fired", fired, 4'b0101);
    chk("alive_dropped", dropped, 4'b0000);
    chk("alive_valid", bValid, 16'hF1F1);
    chk("alive_e0s0", slotPos(0, 0), {10'd230, 9'd48});

    // bottom-border retire at 455 -> 460, and 450 -> 455 survives
    hitClear = 16'h000F;
    step(1);
    hitClear = '0;
    alive = 4'b0001;
    setEnemy(0, 10'd230, 9'd455);
    fireOnce();
    chk("y455_birth", slotPos(0, 0), {10'd230, 9'd455});
    tickOnce();
    chk("y455_retire_v", bValid[0], 1'b0);
    chk("y455_retire_p", slotPos(0, 0), 19'h7FFFF);
    setEnemy(0, 10'd230, 9'd450);
    fireOnce();
    tickOnce();
    chk("y450_valid", bValid[0], 1'b1);
    chk("y450_pos", slotPos(0, 0), {10'd230, 9'd455});

    // retire and fire on the same tick: allocation skips the retiring slot
    setEnemy(0, 10'd230, 9'd100);
    fireOnce();
    chk("sametick_valid", bValid[3:0], 4'b0010);
    chk("sametick_s1", slotPos(0, 1), {10'd230, 9'd100});
    chk("sametick_s0", slotPos(0, 0), 19'h7FFFF);

    // hit clear on the target slot does not block allocation
    hitClear = 16'h0001;
    fireOnce();
    hitClear = '0;
    chk("hitalloc_valid", bValid[3:0], 4'b0011);
    chk("hitalloc_s0", slotPos(0, 0), {10'd230, 9'd100});

    // enable low freezes counter, motion and fire
    en = 1'b0; tick = 1'b1; fireNow = 1'b1;
    step(3);
    chk("freeze_cnt", fireCnt, 7'd12);
    chk("freeze_s1", slotPos(0, 1), {10'd230, 9'd105});
    chk("freeze_fired", fired, 4'b0000);
    fireNow = 1'b0;

    // long run with a periodic fire and natural retires
    en = 1'b1; alive = 4'b1010;
    step(130);

    // reset mid-flight
    rst = 1'b0;
    #1;
    chk("midrst_valid", bValid, 16'h0000);
    chk("midrst_cnt", fireCnt, 7'd0);
    chk("midrst_fired", fired, 4'b0000);
    step(2);
    rst = 1'b1;
    step(10);
    tick = 1'b0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
